// File: rtl/fruit_dropper_if.sv
// Drawer handshake bundle for fruit_dropper.
// Carries the fruit position plus the req/ack draw handshake.
interface fruit_dropper_if;
  logic       DrawReq;
  logic       DrawAck;
  logic [3:0] FruitX;
  logic [3:0] FruitY;
  logic       FruitValid;

  modport master (
    output DrawReq, FruitX, FruitY, FruitValid,
    input  DrawAck
  );

  modport slave (
    input  DrawReq, FruitX, FruitY, FruitValid,
    output DrawAck
  );
endinterface

// File: rtl/fruit_dropper.sv
// fruit_dropper: spawns, drops and resolves one fruit at a time.
// Define FRUIT_SPEEDUP_EN to skip the spawn gap after four catches.
module fruit_dropper #(
  parameter int         LANES     = 8,
  parameter int         ROWS      = 15,
  parameter int         SPAWN_GAP = 2,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic            CLOCK_50,
  input  logic            Reset,
  input  logic            GameActive,
  input  logic            DropTick,
  input  logic [3:0]      CharPos,
  output logic            Caught,
  output logic            Missed,
  fruit_dropper_if.master draw
);
  localparam int         LW   = $clog2(LANES);
  localparam int         GW   = $clog2(SPAWN_GAP + 1);
  localparam logic [3:0] LAST = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, GAP, SPAWN, DRAW, FALL, RESOLVE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    lfsr;
  logic [GW-1:0] gap, gap_n;
  logic [3:0]    x, x_n;
  logic [3:0]    y, y_n;
  logic          valid, valid_n;
  logic          req, req_n;
  logic          pend, pend_n;
  logic          go_spawn;
  logic          resolving;

  assign resolving = GameActive && (state == RESOLVE);
  assign Caught    = resolving && (CharPos == x);
  assign Missed    = resolving && (CharPos != x);

`ifdef FRUIT_SPEEDUP_EN
  logic [2:0] catches, catches_n;

  always_comb begin
    catches_n = catches;
    if (!GameActive)
      catches_n = '0;
    else if (Caught && catches != 3'd7)
      catches_n = catches + 3'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge Reset)
    if (!Reset) catches <= '0;
    else        catches <= catches_n;

  // Includes the catch being resolved this cycle.
  assign go_spawn = (catches_n >= 3'd4);
`else
  assign go_spawn = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge Reset)
    if (!Reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

  always_comb begin
    state_n = state;
    gap_n   = gap;
    x_n     = x;
    y_n     = y;
    valid_n = valid;
    req_n   = req;
    pend_n  = pend;
    if (!GameActive) begin
      state_n = IDLE;
      valid_n = 1'b0;
      req_n   = 1'b0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = GAP;
          gap_n   = GW'(SPAWN_GAP);
        end
        GAP: if (DropTick) begin
          gap_n = gap - GW'(1);
          if (gap == GW'(1)) state_n = SPAWN;
        end
        SPAWN: begin
          x_n     = 4'(lfsr[LW-1:0]);
          y_n     = 4'd0;
          valid_n = 1'b1;
          req_n   = 1'b1;
          state_n = DRAW;
        end
        DRAW: begin
          if (DropTick) pend_n = 1'b1;
          if (draw.DrawAck) begin
            req_n   = 1'b0;
            state_n = FALL;
          end
        end
        FALL: if (DropTick || pend) begin
          pend_n = 1'b0;
          if (y == LAST) begin
            state_n = RESOLVE;
          end else begin
            y_n     = y + 4'd1;
            req_n   = 1'b1;
            state_n = DRAW;
          end
        end
        RESOLVE: begin
          valid_n = 1'b0;
          gap_n   = GW'(SPAWN_GAP);
          state_n = go_spawn ? SPAWN : GAP;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      gap   <= '0;
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
      req   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
      x     <= x_n;
      y     <= y_n;
      valid <= valid_n;
      req   <= req_n;
      pend  <= pend_n;
    end

  assign draw.FruitX     = x;
  assign draw.FruitY     = y;
  assign draw.FruitValid = valid;
  assign draw.DrawReq    = req;
endmodule
